// File: rtl/codificador_pkg.sv
// Shared types, code-select values and the 2-of-5 table
// for the sequential BCD digit encoder.
package codificador_pkg;

   localparam int DIG_W  = 4;
   localparam int CODE_W = 5;

   localparam logic [1:0] MODE_2OF5 = 2'd0;
   localparam logic [1:0] MODE_XS3  = 2'd1;
   localparam logic [1:0] MODE_GRAY = 2'd2;
   localparam logic [1:0] MODE_BIN  = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      ENCODE,
      DONE
   } state_t;

   // Weights 7-4-2-1-0; zero uses the 7+4 pair
   function automatic logic [CODE_W-1:0] two_of_five(
      input logic [DIG_W-1:0] d
   );
      logic [CODE_W-1:0] c;
      case (d)
         4'd0:    c = 5'b11000;
         4'd1:    c = 5'b00011;
         4'd2:    c = 5'b00101;
         4'd3:    c = 5'b00110;
         4'd4:    c = 5'b01001;
         4'd5:    c = 5'b01010;
         4'd6:    c = 5'b01100;
         4'd7:    c = 5'b10001;
         4'd8:    c = 5'b10010;
         4'd9:    c = 5'b10100;
         default: c = 5'b00000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/codificador_digito.sv
// Single-digit encoder: maps one nibble to a 5-bit code word
// in the selected code, flagging digits the code cannot represent.
module codificador_digito
   import codificador_pkg::*;
(
   input  logic [DIG_W-1:0]  digit,
   input  logic [1:0]        mode,
   output logic [CODE_W-1:0] code,
   output logic              invalid
);

   always_comb begin
      code    = '0;
      invalid = 1'b0;
      unique case (mode)
         MODE_2OF5: begin
            if (digit > 4'd9) invalid = 1'b1;
            else code = two_of_five(digit);
         end
         MODE_XS3: begin
            if (digit > 4'd9) invalid = 1'b1;
            else code = {1'b0, digit + 4'd3};
         end
         MODE_GRAY: code = {1'b0, digit ^ (digit >> 1)};
         MODE_BIN:  code = {1'b0, digit};
      endcase
   end

endmodule

// File: rtl/codificador_bcd_seq.sv
// Sequential BCD word encoder: accepts a packed digit word, encodes
// one digit per clock, then holds the packed result until taken.
module codificador_bcd_seq
   import codificador_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DIG_W*DIGITS-1:0]  in_data,
   input  logic [1:0]               mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CODE_W*DIGITS-1:0] out_data,
   output logic [DIGITS-1:0]        err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t                    state, state_n;
   logic [IW-1:0]             idx;
   logic [DIG_W*DIGITS-1:0]   data_q;
   logic [1:0]                mode_q;
   logic [DIG_W-1:0]          digit;
   logic [CODE_W-1:0]         code;
   logic                      invalid;
   logic                      last;

   assign last      = (idx == IW'(DIGITS - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      digit = '0;
      for (int k = 0; k < DIGITS; k++)
         if (idx == IW'(k)) digit = data_q[DIG_W*k +: DIG_W];
   end

   codificador_digito u_digito (
      .digit   (digit),
      .mode    (mode_q),
      .code    (code),
      .invalid (invalid)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid)  state_n = ENCODE;
         ENCODE:  if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Results persist after hand-off; only a new accept clears them
   always_ff @(posedge clk) begin
      if (reset) begin
         idx      <= '0;
         data_q   <= '0;
         mode_q   <= '0;
         out_data <= '0;
         err      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= in_data;
                  mode_q   <= mode;
                  out_data <= '0;
                  err      <= '0;
                  idx      <= '0;
               end
            end
            ENCODE: begin
               for (int k = 0; k < DIGITS; k++) begin
                  if (idx == IW'(k)) begin
                     out_data[CODE_W*k +: CODE_W] <= code;
                     err[k]                       <= invalid;
                  end
               end
               idx <= last ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_codificador_bcd_seq.sv
// Randomised and directed bench for codificador_bcd_seq, checked
// against a word-level model of the four digit codes.
module tb_codificador_bcd_seq;

   localparam int D = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [4*D-1:0] in_data;
   logic [1:0]     mode;
   logic           out_valid;
   logic           out_ready;
   logic [5*D-1:0] out_data;
   logic [D-1:0]   err;

   int checks = 0;
   int passes = 0;

   logic [5*D-1:0] exp_d;
   logic [D-1:0]   exp_e;

   logic [4:0] tbl [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110,
                            5'b01001, 5'b01010, 5'b01100, 5'b10001,
                            5'b10010, 5'b10100};

   codificador_bcd_seq #(.DIGITS(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: act=%0h req=%0h", name, act, req);
   endtask

   function automatic void model(input logic [4*D-1:0] d,
                                 input logic [1:0] m,
                                 output logic [5*D-1:0] od,
                                 output logic [D-1:0] oe);
      int v;
      od = '0;
      oe = '0;
      for (int k = 0; k < D; k++) begin
         v = int'(d[4*k +: 4]);
         case (m)
            2'd0: if (v > 9) oe[k] = 1'b1; else od[5*k +: 5] = tbl[v];
            2'd1: if (v > 9) oe[k] = 1'b1; else od[5*k +: 5] = 5'(v + 3);
            2'd2: od[5*k +: 5] = 5'(v ^ (v >> 1));
            default: od[5*k +: 5] = 5'(v);
         endcase
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         chk("out_data", 128'(out_data), 128'(exp_d));
         chk("err", 128'(err), 128'(exp_e));
      end
   end

   task automatic run_txn(input logic [4*D-1:0] d, input logic [1:0] m,
                          input int hold);
      int n;
      int lat;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("in_ready_wait", 128'(n < 50), 128'(1));
      model(d, m, exp_d, exp_e);
      in_data   = d;
      mode      = m;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      mode     = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < D + 5) begin
         tick();
         lat++;
      end
      chk("latency", 128'(lat), 128'(D));
      chk("in_ready_done", 128'(in_ready), 128'(0));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 16'($urandom);
         mode     = 2'($urandom);
         tick();
         chk("hold_valid", 128'(out_valid), 128'(1));
         chk("hold_ready", 128'(in_ready), 128'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("handoff_valid", 128'(out_valid), 128'(0));
      chk("handoff_ready", 128'(in_ready), 128'(1));
      chk("held_data", 128'(out_data), 128'(exp_d));
      chk("held_err", 128'(err), 128'(exp_e));
   endtask

   task automatic pin(input logic [4*D-1:0] d, input logic [1:0] m,
                      input logic [5*D-1:0] ld, input logic [D-1:0] le);
      logic [5*D-1:0] md;
      logic [D-1:0]   me;
      model(d, m, md, me);
      chk("pin_data", 128'(md), 128'(ld));
      chk("pin_err", 128'(me), 128'(le));
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      mode      = '0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_data", 128'(out_data), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_ready", 128'(in_ready), 128'(1));

      pin(16'h1234, 2'd0, 20'b00011_00101_00110_01001, 4'b0000);
      pin(16'h9A05, 2'd1, 20'b01100_00000_00011_01000, 4'b0100);
      pin(16'hF0F1, 2'd2, 20'b01000_00000_01000_00001, 4'b0000);
      pin(16'hF0F1, 2'd3, 20'b01111_00000_01111_00001, 4'b0000);

      run_txn(16'h1234, 2'd0, 0);
      chk("lit_1234", 128'(out_data), 128'(20'b00011_00101_00110_01001));
      run_txn(16'h9A05, 2'd1, 1);
      chk("lit_9A05_err", 128'(err), 128'(4'b0100));
      run_txn(16'hF0F1, 2'd2, 0);
      run_txn(16'hF0F1, 2'd3, 10);

      // reset while the third digit is being encoded
      in_data  = 16'h5678;
      mode     = 2'd0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_data", 128'(out_data), 128'(0));
      chk("mid_rst_err", 128'(err), 128'(0));
      chk("mid_rst_ready", 128'(in_ready), 128'(1));
      run_txn(16'h0987, 2'd0, 2);

      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 2)) tick();
         run_txn(16'($urandom), 2'($urandom), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
